uart_rx_deser: RTL

- Parametrised UART receive deserializer.
- Collects W_DATA serial data bits, LSB- or MSB-first, on bit-timing strobes, plus an optional parity bit.
- Transfers each completed word into a holding register, presented through a valid/ready handshake with parity and overrun status.
- Sits between the RX bit-timing/start-detect logic and the RX FIFO/register interface.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/deser_shreg.sv | 38 +++
 rtl/uart_rx_deser.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and limits for the UART receive deserializer.
package uart_pkg;

  localparam int W_DATA_MAX = 16;
  localparam int W_CNT      = $clog2(W_DATA_MAX + 1);

  typedef enum logic [1:0] {
    PM_NONE = 2'd0,
    PM_EVEN = 2'd1,
    PM_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } deser_state_t;

endpackage

// File: rtl/deser_shreg.sv
// Enable/clear shift register that assembles the serial data word, LSB- or MSB-first.
module deser_shreg
  import uart_pkg::*;
#(
  parameter int W_DATA    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic [W_DATA-1:0] word,
  output logic [W_DATA-1:0] word_shift,
  output logic              par
);

  logic [W_DATA-1:0] shreg_d, shreg_q;

  // word_shift is the value the register takes on this enable, so a frame
  // can complete on its final strobe without waiting another cycle.
  always_comb begin
    if (MSB_FIRST) word_shift = {shreg_q[W_DATA-2:0], bit_in};
    else           word_shift = {bit_in, shreg_q[W_DATA-1:1]};
    shreg_d = shreg_q;
    if (clr)     shreg_d = '0;
    else if (en) shreg_d = word_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) shreg_q <= '0;
    else      shreg_q <= shreg_d;
  end

  assign word = shreg_q;
  assign par  = ^shreg_q;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: frame FSM, bit counter, holding register and status.
// Optional stop-bit check (STOP state, framing_err) under UART_RX_DESER_STOPCHK_EN.
//
// state   | meaning
// IDLE    | waiting for frame_start, bit_en ignored
// DATA    | shifting in W_DATA data bits
// PAR     | waiting for the parity bit
// STOP    | waiting for the stop bit (stop-check builds only)
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int W_DATA    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              bit_en,
  input  logic              bit_in,
  input  logic [1:0]        parity_mode,
  output logic [W_DATA-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              overrun,
  input  logic              clr_status,
  output logic              busy
`ifdef UART_RX_DESER_STOPCHK_EN
  ,
  output logic              framing_err
`endif
);

  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(W_DATA - 1);

  deser_state_t      state_d, state_q;
  logic [W_CNT-1:0]  cnt_d, cnt_q;
  logic [1:0]        mode_d, mode_q;
  logic [W_DATA-1:0] data_d, data_q;
  logic              valid_d, valid_q;
  logic              perr_d, perr_q;
  logic              ovr_d, ovr_q;

  logic              sh_clr, sh_en, sh_par;
  logic [W_DATA-1:0] sh_word, sh_shift;
  logic              complete, load;
  logic [W_DATA-1:0] word_c;
  logic              perr_c, par_on, par_calc;

`ifdef UART_RX_DESER_STOPCHK_EN
  logic perr_pend_d, perr_pend_q;
  logic ferr_d, ferr_q;
  logic ferr_c;
`endif

  deser_shreg #(
    .W_DATA    (W_DATA),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .clr        (sh_clr),
    .en         (sh_en),
    .bit_in     (bit_in),
    .word       (sh_word),
    .word_shift (sh_shift),
    .par        (sh_par)
  );

  assign par_on   = (mode_q == PM_EVEN) || (mode_q == PM_ODD);
  assign par_calc = sh_par ^ bit_in ^ (mode_q == PM_ODD);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    sh_clr   = 1'b0;
    sh_en    = 1'b0;
    complete = 1'b0;
    word_c   = sh_word;
    perr_c   = 1'b0;
`ifdef UART_RX_DESER_STOPCHK_EN
    perr_pend_d = perr_pend_q;
    ferr_c      = 1'b0;
`endif
    if (frame_start) begin
      state_d = ST_DATA;
      cnt_d   = '0;
      mode_d  = parity_mode;
      sh_clr  = 1'b1;
`ifdef UART_RX_DESER_STOPCHK_EN
      perr_pend_d = 1'b0;
`endif
    end else if (bit_en) begin
      case (state_q)
        ST_DATA: begin
          sh_en = 1'b1;
          cnt_d = cnt_q + W_CNT'(1);
          if (cnt_q == CNT_LAST) begin
            if (par_on) begin
              state_d = ST_PAR;
            end else begin
`ifdef UART_RX_DESER_STOPCHK_EN
              state_d = ST_STOP;
`else
              state_d  = ST_IDLE;
              complete = 1'b1;
              word_c   = sh_shift;
`endif
            end
          end
        end
        ST_PAR: begin
`ifdef UART_RX_DESER_STOPCHK_EN
          state_d     = ST_STOP;
          perr_pend_d = par_calc;
`else
          state_d  = ST_IDLE;
          complete = 1'b1;
          perr_c   = par_calc;
`endif
        end
`ifdef UART_RX_DESER_STOPCHK_EN
        ST_STOP: begin
          state_d  = ST_IDLE;
          complete = 1'b1;
          perr_c   = perr_pend_q;
          ferr_c   = ~bit_in;
        end
`endif
        default: ;
      endcase
    end
  end

  // A finished word only replaces the holding register when it is empty or
  // being popped in the same cycle; otherwise it is dropped as an overrun.
  assign load = complete && (!valid_q || data_ready);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_DESER_STOPCHK_EN
    ferr_d  = ferr_q;
`endif
    if (valid_q && data_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = word_c;
      perr_d  = perr_c;
`ifdef UART_RX_DESER_STOPCHK_EN
      ferr_d  = ferr_c;
`endif
    end
    if (clr_status)          ovr_d = 1'b0;
    if (complete && !load)   ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_DESER_STOPCHK_EN
      perr_pend_q <= 1'b0;
      ferr_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_DESER_STOPCHK_EN
      perr_pend_q <= perr_pend_d;
      ferr_q      <= ferr_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef UART_RX_DESER_STOPCHK_EN
  assign framing_err = ferr_q;
`endif

endmodule
